// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU control sequencer.
// Optional feature macro: ALU_CTRL_ILLEGAL_TRAP_EN (illegal opcodes trap to HALT).
package alu_ctrl_pkg;

   localparam int unsigned INSTR_W     = 16;
   localparam int unsigned MAJOR_MSB   = 15;
   localparam int unsigned MAJOR_LSB   = 12;
   localparam int unsigned ALUOP_MSB   = 11;
   localparam int unsigned ALUOP_LSB   = 8;
   localparam int unsigned IMM_MSB     = 7;
   localparam int unsigned IMM_LSB     = 0;
   localparam int unsigned REG_MSB     = 2;
   localparam int unsigned REG_LSB     = 0;
   localparam int unsigned FIELD_OP_W  = ALUOP_MSB - ALUOP_LSB + 1;
   localparam int unsigned FIELD_IMM_W = IMM_MSB - IMM_LSB + 1;
   localparam int unsigned FIELD_REG_W = REG_MSB - REG_LSB + 1;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_MEM    = 3'd4;
   localparam logic [2:0] ST_HALT   = 3'd5;

   typedef enum logic [3:0] {
      OP_NOP     = 4'h0,
      OP_ALU_REG = 4'h1,
      OP_ALU_IMM = 4'h2,
      OP_ALU_MEM = 4'h3,
      OP_STORE   = 4'h4,
      OP_JMP     = 4'h5,
      OP_JC      = 4'h6,
      OP_JZ      = 4'h7,
      OP_HALT    = 4'hF
   } major_op_e;

   typedef enum logic [1:0] {
      BR_NONE = 2'd0,
      BR_JMP  = 2'd1,
      BR_JC   = 2'd2,
      BR_JZ   = 2'd3
   } branch_e;

   typedef struct packed {
      logic                   acu_ce;       // instruction loads the accumulator
      logic                   direct_load;  // operand is the immediate field
      logic                   mem_rd;       // operand comes from data memory
      logic                   rf_ce;        // accumulator written to register file
      logic                   use_reg;      // register address field is meaningful
      branch_e                branch;
      logic                   halt;
      logic                   illegal;
      logic [FIELD_OP_W-1:0]  opcode;
      logic [FIELD_IMM_W-1:0] imm;
      logic [FIELD_REG_W-1:0] reg_addr;
   } ctrl_word_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational instruction decoder: 16-bit instruction -> control word.
// Optional feature macro: ALU_CTRL_ILLEGAL_TRAP_EN flags unknown major ops as illegal.
module alu_ctrl_decode
   import alu_ctrl_pkg::*;
(
   input  logic [INSTR_W-1:0] i_instr,
   output ctrl_word_t         o_ctrl
);

   // Map the major opcode onto control-word fields
   always_comb begin
      o_ctrl          = '0;
      o_ctrl.branch   = BR_NONE;
      o_ctrl.opcode   = i_instr[ALUOP_MSB:ALUOP_LSB];
      o_ctrl.imm      = i_instr[IMM_MSB:IMM_LSB];
      o_ctrl.reg_addr = i_instr[REG_MSB:REG_LSB];
      case (i_instr[MAJOR_MSB:MAJOR_LSB])
         OP_NOP:     ;
         OP_ALU_REG: begin o_ctrl.acu_ce = 1'b1; o_ctrl.use_reg = 1'b1; end
         OP_ALU_IMM: begin o_ctrl.acu_ce = 1'b1; o_ctrl.direct_load = 1'b1; end
         OP_ALU_MEM: begin o_ctrl.acu_ce = 1'b1; o_ctrl.mem_rd = 1'b1; end
         OP_STORE:   begin o_ctrl.rf_ce = 1'b1; o_ctrl.use_reg = 1'b1; end
         OP_JMP:     o_ctrl.branch = BR_JMP;
         OP_JC:      o_ctrl.branch = BR_JC;
         OP_JZ:      o_ctrl.branch = BR_JZ;
         OP_HALT:    o_ctrl.halt = 1'b1;
         default: begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            o_ctrl.illegal = 1'b1;
`endif
         end
      endcase
   end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// Instruction sequencer: fetches from a synchronous ROM, decodes, and drives
// one-cycle ALU control strobes. All outputs are registered and aligned with
// the FSM state they belong to.
// Optional feature macro: ALU_CTRL_ILLEGAL_TRAP_EN (illegal op -> o_illegal, HALT).
module alu_ctrl_sequencer
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PC_WIDTH   = 8,
   parameter int unsigned RF_ADDR_W  = 3,
   parameter int unsigned OPCODE_W   = 4
)(
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   output logic [PC_WIDTH-1:0]   o_prog_addr,
   output logic                  o_prog_re,
   input  logic [INSTR_W-1:0]    i_prog_data,
   input  logic                  i_carry,
   input  logic [DATA_WIDTH-1:0] i_acumulator,
   output logic [OPCODE_W-1:0]   o_operation_code,
   output logic                  o_acumulator_ce,
   output logic                  o_register_file_ce,
   output logic [RF_ADDR_W-1:0]  o_register_file_mux_addr,
   output logic                  o_data_memory_read_enable,
   output logic [DATA_WIDTH-1:0] o_data_memory_addr,
   output logic [DATA_WIDTH-1:0] o_direct_data,
   output logic                  o_direct_load,
   output logic                  o_halted,
   output logic                  o_illegal
);

   logic [2:0]            state_q, state_d;
   logic [PC_WIDTH-1:0]   pc_q, pc_d;
   logic [INSTR_W-1:0]    instr_q, instr_d, instr_sel;
   logic                  illegal_q, illegal_d;
   logic                  prog_re_q, prog_re_d;
   logic [OPCODE_W-1:0]   opcode_q, opcode_d;
   logic                  acu_ce_q, acu_ce_d;
   logic                  rf_ce_q, rf_ce_d;
   logic [RF_ADDR_W-1:0]  rf_addr_q, rf_addr_d;
   logic                  dm_re_q, dm_re_d;
   logic [DATA_WIDTH-1:0] dm_addr_q, dm_addr_d;
   logic [DATA_WIDTH-1:0] direct_data_q, direct_data_d;
   logic                  direct_load_q, direct_load_d;
   logic                  halted_q, halted_d;
   ctrl_word_t            ctrl;
   logic                  taken_c;

   // Decode the ROM word directly in DECODE so EXEC outputs can be registered
   always_comb instr_sel = (state_q == ST_DECODE) ? i_prog_data : instr_q;

   alu_ctrl_decode u_decode (
      .i_instr (instr_sel),
      .o_ctrl  (ctrl)
   );

   // Branch condition evaluated against live ALU flags during EXEC
   always_comb begin
      taken_c = 1'b0;
      case (ctrl.branch)
         BR_JMP:  taken_c = 1'b1;
         BR_JC:   taken_c = i_carry;
         BR_JZ:   taken_c = (i_acumulator == '0);
         default: taken_c = 1'b0;
      endcase
   end

   // Next state, PC, instruction register and sticky illegal flag
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      illegal_d = illegal_q;
      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (i_start) begin
               state_d   = ST_FETCH;
               pc_d      = '0;
               illegal_d = 1'b0;
            end
         end
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: begin
            instr_d = i_prog_data;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (ctrl.illegal) begin
               illegal_d = 1'b1;
               state_d   = ST_HALT;
            end else if (ctrl.halt) begin
               state_d = ST_HALT;
            end else if (ctrl.mem_rd) begin
               state_d = ST_MEM;
            end else begin
               state_d = ST_FETCH;
               pc_d    = taken_c ? PC_WIDTH'(ctrl.imm) : pc_q + PC_WIDTH'(1);
            end
         end
         ST_MEM: begin
            state_d = ST_FETCH;
            pc_d    = pc_q + PC_WIDTH'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output register inputs, keyed on the state being entered
   always_comb begin
      prog_re_d     = (state_d == ST_FETCH);
      halted_d      = (state_d == ST_HALT);
      opcode_d      = '0;
      acu_ce_d      = 1'b0;
      rf_ce_d       = 1'b0;
      rf_addr_d     = '0;
      dm_re_d       = 1'b0;
      dm_addr_d     = '0;
      direct_data_d = '0;
      direct_load_d = 1'b0;
      if (state_d == ST_EXEC) begin
         acu_ce_d      = ctrl.acu_ce & ~ctrl.mem_rd;
         opcode_d      = acu_ce_d ? OPCODE_W'(ctrl.opcode) : '0;
         direct_load_d = ctrl.direct_load;
         direct_data_d = ctrl.direct_load ? DATA_WIDTH'(ctrl.imm) : '0;
         rf_ce_d       = ctrl.rf_ce;
         rf_addr_d     = ctrl.use_reg ? RF_ADDR_W'(ctrl.reg_addr) : '0;
         dm_re_d       = ctrl.mem_rd;
         dm_addr_d     = ctrl.mem_rd ? DATA_WIDTH'(ctrl.imm) : '0;
      end else if (state_d == ST_MEM) begin
         acu_ce_d  = 1'b1;
         opcode_d  = OPCODE_W'(ctrl.opcode);
         dm_re_d   = 1'b1;
         dm_addr_d = DATA_WIDTH'(ctrl.imm);
      end
   end

   // State and output registers
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q       <= ST_IDLE;
         pc_q          <= '0;
         instr_q       <= '0;
         illegal_q     <= 1'b0;
         prog_re_q     <= 1'b0;
         opcode_q      <= '0;
         acu_ce_q      <= 1'b0;
         rf_ce_q       <= 1'b0;
         rf_addr_q     <= '0;
         dm_re_q       <= 1'b0;
         dm_addr_q     <= '0;
         direct_data_q <= '0;
         direct_load_q <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         illegal_q     <= illegal_d;
         prog_re_q     <= prog_re_d;
         opcode_q      <= opcode_d;
         acu_ce_q      <= acu_ce_d;
         rf_ce_q       <= rf_ce_d;
         rf_addr_q     <= rf_addr_d;
         dm_re_q       <= dm_re_d;
         dm_addr_q     <= dm_addr_d;
         direct_data_q <= direct_data_d;
         direct_load_q <= direct_load_d;
         halted_q      <= halted_d;
      end
   end

   assign o_prog_addr               = pc_q;
   assign o_prog_re                 = prog_re_q;
   assign o_operation_code          = opcode_q;
   assign o_acumulator_ce           = acu_ce_q;
   assign o_register_file_ce        = rf_ce_q;
   assign o_register_file_mux_addr  = rf_addr_q;
   assign o_data_memory_read_enable = dm_re_q;
   assign o_data_memory_addr        = dm_addr_q;
   assign o_direct_data             = direct_data_q;
   assign o_direct_load             = direct_load_q;
   assign o_halted                  = halted_q;
   assign o_illegal                 = illegal_q;

endmodule
